// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter
//
// Lets num_req_p request sources (loads, stores, AMOs) share one bsg_cache
// packet input. Requesters are served round-robin. Once a packet has been
// offered to the cache, the grant is held on that requester until the cache
// accepts it. The requester ID of every accepted packet is pushed into an
// in-order tag FIFO. Cache responses come back in order, so the FIFO head
// names the requester that owns the current response. The FIFO occupancy
// doubles as the outstanding-request count, and it limits in-flight requests
// to max_outstanding_p.
//
// Ports
//   clk_i          clock
//   reset_i        synchronous, active-high reset
//   req_v_i        per-requester packet valid
//   req_pkt_i      per-requester packets, requester i in [i*pkt_width_p +: pkt_width_p]
//   req_ready_o    per-requester accept (one-hot or zero)
//   cache_v_o      packet valid to cache (independent of cache_ready_i)
//   cache_pkt_o    granted packet
//   cache_ready_i  cache accepts packet
//   cache_data_i   cache response data
//   cache_v_i      cache response valid
//   cache_yumi_o   cache response consumed
//   resp_v_o       one-hot response valid to the owning requester
//   resp_data_o    response data, shared by all requesters
//   resp_yumi_i    per-requester response consume
//   outstanding_o  issued-but-unanswered request count

module cache_req_arbiter #(
    parameter int unsigned num_req_p         = 4,
    parameter int unsigned pkt_width_p       = 16,
    parameter int unsigned data_width_p      = 32,
    parameter int unsigned max_outstanding_p = 4,
    localparam int unsigned id_width_lp      = (num_req_p > 1) ? $clog2(num_req_p) : 1,
    localparam int unsigned count_width_lp   = $clog2(max_outstanding_p + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,

    input  logic [num_req_p-1:0]                 req_v_i,
    input  logic [num_req_p*pkt_width_p-1:0]     req_pkt_i,
    output logic [num_req_p-1:0]                 req_ready_o,

    output logic                                 cache_v_o,
    output logic [pkt_width_p-1:0]               cache_pkt_o,
    input  logic                                 cache_ready_i,

    input  logic [data_width_p-1:0]              cache_data_i,
    input  logic                                 cache_v_i,
    output logic                                 cache_yumi_o,

    output logic [num_req_p-1:0]                 resp_v_o,
    output logic [data_width_p-1:0]              resp_data_o,
    input  logic [num_req_p-1:0]                 resp_yumi_i,

    output logic [count_width_lp-1:0]            outstanding_o
);

    localparam int unsigned ptr_width_lp =
        (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

    localparam logic [count_width_lp-1:0] max_count_lp = count_width_lp'(max_outstanding_p);
    localparam logic [ptr_width_lp-1:0]   ptr_last_lp  = ptr_width_lp'(max_outstanding_p - 1);
    localparam logic [id_width_lp-1:0]    id_last_lp   = id_width_lp'(num_req_p - 1);
    localparam logic [id_width_lp:0]      num_req_ext_lp = (id_width_lp + 1)'(num_req_p);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [id_width_lp-1:0]    r_rr_ptr;
    logic                      r_hold;
    logic [id_width_lp-1:0]    r_held_id;
    logic [id_width_lp-1:0]    r_tags [max_outstanding_p];
    logic [ptr_width_lp-1:0]   r_wr_ptr;
    logic [ptr_width_lp-1:0]   r_rd_ptr;
    logic [count_width_lp-1:0] r_count;

    // ------------------------------------------------------------------
    // Round-robin search
    // ------------------------------------------------------------------
    // The valid vector is duplicated so that a plain part-select starting at
    // the pointer gives the requests rotated into pointer-relative order.
    logic [2*num_req_p-1:0] w_req_dbl;
    logic [num_req_p-1:0]   w_req_rot;
    logic                   w_rr_found;
    logic [id_width_lp-1:0] w_rr_offset;
    logic [id_width_lp:0]   w_rr_sum;
    logic [id_width_lp-1:0] w_rr_grant;

    assign w_req_dbl = {req_v_i, req_v_i};
    assign w_req_rot = w_req_dbl[r_rr_ptr +: num_req_p];

    always_comb begin
        w_rr_found  = 1'b0;
        w_rr_offset = '0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            if (!w_rr_found && w_req_rot[k]) begin
                w_rr_found  = 1'b1;
                w_rr_offset = id_width_lp'(k);
            end
        end
    end

    // Map the rotated offset back to an absolute ID (pointer + offset mod N).
    always_comb begin
        w_rr_sum = {1'b0, r_rr_ptr} + {1'b0, w_rr_offset};
        if (w_rr_sum >= num_req_ext_lp) begin
            w_rr_sum = w_rr_sum - num_req_ext_lp;
        end
        w_rr_grant = w_rr_sum[id_width_lp-1:0];
    end

    // ------------------------------------------------------------------
    // Grant and request-side outputs
    // ------------------------------------------------------------------
    logic                   w_grant_v;
    logic [id_width_lp-1:0] w_grant;
    logic                   w_issue_ok;
    logic                   w_cache_v;
    logic                   w_fire;
    logic [pkt_width_p-1:0] w_grant_pkt;

    // A stalled packet keeps its grant so that the cache sees a stable request.
    assign w_grant    = r_hold ? r_held_id : w_rr_grant;
    assign w_grant_v  = r_hold ? req_v_i[r_held_id] : w_rr_found;
    assign w_issue_ok = (r_count < max_count_lp);
    assign w_cache_v  = ~reset_i & w_issue_ok & w_grant_v;
    assign w_fire     = w_cache_v & cache_ready_i;

    always_comb begin
        w_grant_pkt = '0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            if (id_width_lp'(k) == w_grant) begin
                w_grant_pkt = req_pkt_i[k*pkt_width_p +: pkt_width_p];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            req_ready_o[k] = w_fire & (id_width_lp'(k) == w_grant);
        end
    end

    assign cache_v_o   = w_cache_v;
    assign cache_pkt_o = w_grant_pkt;

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    logic                   w_nonempty;
    logic [id_width_lp-1:0] w_head;
    logic                   w_resp_active;
    logic                   w_pop;

    // The FIFO occupancy equals the outstanding count.
    assign w_nonempty    = (r_count != '0);
    assign w_head        = r_tags[r_rd_ptr];
    assign w_resp_active = ~reset_i & cache_v_i & w_nonempty;
    assign w_pop         = w_resp_active & resp_yumi_i[w_head];

    always_comb begin
        resp_v_o = '0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            resp_v_o[k] = w_resp_active & (id_width_lp'(k) == w_head);
        end
    end

    assign resp_data_o   = cache_data_i;
    assign cache_yumi_o  = w_pop;
    assign outstanding_o = r_count;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rr_ptr  <= '0;
            r_hold    <= 1'b0;
            r_held_id <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (w_fire) begin
                r_rr_ptr <= (w_grant == id_last_lp) ? '0 : w_grant + id_width_lp'(1);
                r_hold   <= 1'b0;
                r_wr_ptr <= (r_wr_ptr == ptr_last_lp) ? '0 : r_wr_ptr + ptr_width_lp'(1);
            end else if (w_cache_v) begin
                r_hold    <= 1'b1;
                r_held_id <= w_grant;
            end

            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == ptr_last_lp) ? '0 : r_rd_ptr + ptr_width_lp'(1);
            end

            unique case ({w_fire, w_pop})
                2'b10:   r_count <= r_count + count_width_lp'(1);
                2'b01:   r_count <= r_count - count_width_lp'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read while the count
    // says they are valid.
    always_ff @(posedge clk_i) begin
        if (!reset_i && w_fire) begin
            r_tags[r_wr_ptr] <= w_grant;
        end
    end

    // A response with nothing outstanding has no owner.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(cache_v_i && !w_nonempty))
                else $error("cache_req_arbiter: cache response with no outstanding request");
        end
    end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Testbench for cache_req_arbiter: directed scenarios followed by randomized
// traffic, all checked against a queue-based reference model.

module tb_cache_req_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 16;
    localparam int unsigned D   = 32;
    localparam int unsigned MAX = 4;
    localparam int unsigned CW  = 3;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [N-1:0]    req_v_i;
    logic [N*W-1:0]  req_pkt_i;
    logic [N-1:0]    req_ready_o;
    logic            cache_v_o;
    logic [W-1:0]    cache_pkt_o;
    logic            cache_ready_i;
    logic [D-1:0]    cache_data_i;
    logic            cache_v_i;
    logic            cache_yumi_o;
    logic [N-1:0]    resp_v_o;
    logic [D-1:0]    resp_data_o;
    logic [N-1:0]    resp_yumi_i;
    logic [CW-1:0]   outstanding_o;

    always #5 clk_i = ~clk_i;

    cache_req_arbiter #(
        .num_req_p         (N),
        .pkt_width_p       (W),
        .data_width_p      (D),
        .max_outstanding_p (MAX)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .req_v_i       (req_v_i),
        .req_pkt_i     (req_pkt_i),
        .req_ready_o   (req_ready_o),
        .cache_v_o     (cache_v_o),
        .cache_pkt_o   (cache_pkt_o),
        .cache_ready_i (cache_ready_i),
        .cache_data_i  (cache_data_i),
        .cache_v_i     (cache_v_i),
        .cache_yumi_o  (cache_yumi_o),
        .resp_v_o      (resp_v_o),
        .resp_data_o   (resp_data_o),
        .resp_yumi_i   (resp_yumi_i),
        .outstanding_o (outstanding_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Requester side: a pending request keeps its packet until accepted.
    logic [N-1:0] pending = '0;
    logic [W-1:0] pkt [N];

    // Reference model state.
    int m_rr   = 0;
    bit m_hold = 1'b0;
    int m_held = 0;
    int q[$];

    // DUT outputs seen at the last step's sample point.
    logic          obs_cv;
    logic [N-1:0]  obs_ready;
    logic [W-1:0]  obs_pkt;
    logic [N-1:0]  obs_resp_v;
    logic          obs_yumi;
    logic [CW-1:0] obs_out;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare 1ns later, advance
    // the model, then wait for the next falling edge.
    task automatic step(input logic rst, input logic rdy, input logic cv,
                        input logic [N-1:0] yumi);
        logic [N-1:0] v;
        logic [N-1:0] one;
        logic [N-1:0] erdy;
        logic [N-1:0] erv;
        logic [D-1:0] data;
        logic         ev;
        logic         ey;
        bit           found;
        int           g;
        int           idx;

        one  = 1;
        v    = pending;
        data = $urandom();
        reset_i = rst;
        req_v_i = v;
        for (int i = 0; i < N; i++) begin
            req_pkt_i[i*W +: W] = pkt[i];
        end
        cache_ready_i = rdy;
        cache_v_i     = cv;
        resp_yumi_i   = yumi;
        cache_data_i  = data;
        #1;

        found = m_hold;
        g     = m_held;
        if (!m_hold) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (!found && v[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
        end
        ev   = !rst && (q.size() < MAX) && found && v[g];
        erdy = (ev && rdy) ? (one << g) : '0;
        erv  = '0;
        ey   = 1'b0;
        if (!rst && cv && q.size() > 0) begin
            erv = one << q[0];
            ey  = yumi[q[0]];
        end

        check_eq("cache_v", cache_v_o, ev);
        check_eq("req_ready", req_ready_o, erdy);
        check_eq("cache_yumi", cache_yumi_o, ey);
        check_eq("resp_v", resp_v_o, erv);
        check_eq("resp_data", resp_data_o, data);
        check_eq("outstanding", outstanding_o, q.size());
        if (ev) begin
            check_eq("cache_pkt", cache_pkt_o, pkt[g]);
        end

        obs_cv     = cache_v_o;
        obs_ready  = req_ready_o;
        obs_pkt    = cache_pkt_o;
        obs_resp_v = resp_v_o;
        obs_yumi   = cache_yumi_o;
        obs_out    = outstanding_o;

        if (rst) begin
            m_rr   = 0;
            m_hold = 1'b0;
            m_held = 0;
            q.delete();
        end else begin
            if (ey) begin
                void'(q.pop_front());
            end
            if (ev && rdy) begin
                q.push_back(g);
                m_rr       = (g + 1) % N;
                m_hold     = 1'b0;
                pending[g] = 1'b0;
            end else if (ev) begin
                m_hold = 1'b1;
                m_held = g;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic offer(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            if (mask[i] && !pending[i]) begin
                pending[i] = 1'b1;
                pkt[i]     = W'($urandom());
            end
        end
    endtask

    // Let every pending request issue and every response return.
    task automatic settle();
        for (int i = 0; i < 40 && (q.size() > 0 || pending != '0); i++) begin
            step(1'b0, 1'b1, q.size() > 0, '1);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) pkt[i] = '0;
        reset_i       = 1'b1;
        req_v_i       = '0;
        req_pkt_i     = '0;
        cache_ready_i = 1'b0;
        cache_v_i     = 1'b0;
        cache_data_i  = '0;
        resp_yumi_i   = '0;
        repeat (2) @(negedge clk_i);

        // Reset state and output gating.
        offer('1);
        step(1'b1, 1'b1, 1'b0, '0);
        check_eq("rst_cv", obs_cv, 1'b0);
        check_eq("rst_ready", obs_ready, 4'b0000);
        check_eq("rst_out", obs_out, 0);
        pending = '0;

        // Round-robin fill to the limit, then in-order response routing.
        offer('1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, '0);
            check_eq("rr_ready", obs_ready, 4'b0001 << i);
        end
        offer('1);
        step(1'b0, 1'b1, 1'b0, '0);
        check_eq("full_cv", obs_cv, 1'b0);
        check_eq("full_out", obs_out, 4);
        pending = '0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, '1);
            check_eq("rr_resp", obs_resp_v, 4'b0001 << i);
        end

        // Grant hold under cache backpressure.
        offer(4'b0001);
        step(1'b0, 1'b0, 1'b0, '0);
        check_eq("hold_pkt0", obs_pkt, pkt[0]);
        offer(4'b0010);
        step(1'b0, 1'b0, 1'b0, '0);
        check_eq("hold_pkt1", obs_pkt, pkt[0]);
        step(1'b0, 1'b0, 1'b0, '0);
        check_eq("hold_pkt2", obs_pkt, pkt[0]);
        step(1'b0, 1'b1, 1'b0, '0);
        check_eq("hold_fire0", obs_ready, 4'b0001);
        step(1'b0, 1'b1, 1'b0, '0);
        check_eq("hold_fire1", obs_ready, 4'b0010);
        settle();

        // Sparse request: pointer at 1, only req3 valid.
        offer(4'b0001);
        step(1'b0, 1'b1, 1'b0, '0);
        offer(4'b1000);
        step(1'b0, 1'b1, 1'b0, '0);
        check_eq("sparse_ready", obs_ready, 4'b1000);
        offer('1);
        step(1'b0, 1'b1, 1'b0, '0);
        check_eq("wrap_ready", obs_ready, 4'b0001);

        // Reset with three requests outstanding.
        step(1'b1, 1'b1, 1'b1, '1);
        check_eq("midrst_resp", obs_resp_v, 4'b0000);
        check_eq("midrst_yumi", obs_yumi, 1'b0);
        offer('1);
        step(1'b0, 1'b1, 1'b0, '0);
        check_eq("postrst_out", obs_out, 0);
        check_eq("postrst_grant", obs_ready, 4'b0001);

        // Full with a simultaneous pop: no bypass.
        for (int i = 0; i < 8 && q.size() < MAX; i++) begin
            offer('1);
            step(1'b0, 1'b1, 1'b0, '0);
        end
        offer('1);
        step(1'b0, 1'b1, 1'b1, '1);
        check_eq("nobypass_cv", obs_cv, 1'b0);
        check_eq("nobypass_yumi", obs_yumi, 1'b1);
        check_eq("nobypass_out", obs_out, 4);
        step(1'b0, 1'b1, 1'b0, '0);
        check_eq("resume_out", obs_out, 3);
        check_eq("resume_cv", obs_cv, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0);
        check_eq("refull_out", obs_out, 4);
        settle();

        // Response backpressure with head = 2.
        offer(4'b0100);
        step(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b1, 4'b0000);
            check_eq("bp_resp", obs_resp_v, 4'b0100);
            check_eq("bp_yumi", obs_yumi, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1, 4'b0100);
        check_eq("bp_pop", obs_yumi, 1'b1);
        check_eq("bp_out_before", obs_out, 1);
        step(1'b0, 1'b0, 1'b0, '0);
        check_eq("bp_out_after", obs_out, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            logic rst;
            logic rdy;
            logic cv;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) < 4) offer(4'b0001 << i);
            end
            rst = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            cv  = (q.size() > 0) && ($urandom_range(0, 9) < 6);
            step(rst, rdy, cv, N'($urandom()));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
